register_bank_sequencer: RTL and testbench
==========================================

REGISTER_BANK_SEQUENCER -- requirements
Module: register_bank_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); reset input 1 (asynchronous, active-low).
REQ-002 SHALL provide: instr_valid input 1, instruction/immediate byte offered this cycle.
REQ-003 SHALL provide: instr_data input 8, instruction or immediate byte.
REQ-004 SHALL provide: instr_ready output 1, sequencer accepts instr_data this cycle.
REQ-005 SHALL provide: acc_sel output 1, A input mux control (1 = source path, 0 = ALU result).
REQ-006 SHALL provide: alu_b_sel output 2, ALU B operand select (00 zero, 01 B, 10 C, 11 D).
REQ-007 SHALL provide: bank_out_sel output 2, bank output register select (00 A, 01 B, 10 C, 11 D).
REQ-008 SHALL provide: destination_sel output 4, one-hot load enables, bit0 A .. bit3 D.
REQ-009 SHALL provide: source_sel output 3, source mux (000 A, 001 B, 010 C, 011 D, 100 immediate).
REQ-010 SHALL provide: imm_out output 8, latched immediate, driven to the bank data input.
REQ-011 SHALL provide: alu_op output 2, ALU function code.
REQ-012 SHALL provide: out_strobe output 1, one-cycle pulse marking valid bank output.
REQ-013 SHALL provide: busy output 1, high in any state other than IDLE.
REQ-014 SHALL provide: instr_count output 8, count of completed instructions.

Function
REQ-015 Instruction byte encoding SHALL be: [7:6] class, [5:4] field X, [3:2] field Y, [1:0] field Z.
REQ-016 Classes SHALL be: 00 MOV (rd=X, rs=Y); 01 MVI (rd=X, next byte = immediate); 10 ALU (B operand=X, alu_op=Z, result to A); 11 OUT (register=X).
REQ-017 FSM states SHALL be IDLE, FETCH_IMM, EXEC, WB.
REQ-018 instr_ready SHALL be 1 in IDLE and FETCH_IMM and 0 in EXEC and WB; a transfer occurs on a rising edge where instr_valid and instr_ready are both 1.
REQ-019 IDLE SHALL latch instr_data on a transfer and go to FETCH_IMM for MVI, otherwise to EXEC.
REQ-020 FETCH_IMM SHALL latch instr_data into imm_out on a transfer and go to EXEC; with no transfer it SHALL hold, waiting indefinitely.
REQ-021 EXEC SHALL last exactly one cycle, then go to WB for ALU and to IDLE otherwise.
REQ-022 EXEC for MOV SHALL drive source_sel={0,rs}, destination_sel=onehot(rd) and acc_sel=1; rd==rs is legal and SHALL be issued unchanged.
REQ-023 EXEC for MVI SHALL drive source_sel=100, destination_sel=onehot(rd) and acc_sel=1.
REQ-024 EXEC for ALU SHALL drive alu_b_sel=X, alu_op=Z and destination_sel=0000.
REQ-025 EXEC for OUT SHALL drive bank_out_sel=X and out_strobe=1.
REQ-026 WB SHALL last one cycle, holding alu_b_sel and alu_op from EXEC and driving acc_sel=0 and destination_sel=0001, then go to IDLE.
REQ-027 Outputs SHALL be decoded from state and latched instruction; outside the cycles above, destination_sel=0000, source_sel=000, acc_sel=1, alu_b_sel=00, alu_op=00, bank_out_sel=00 and out_strobe=0.
REQ-028 destination_sel SHALL never have more than one bit set.
REQ-029 Latency SHALL be: MOV/OUT one cycle after the accepting edge; MVI one cycle after the immediate edge; ALU two cycles after the accepting edge.
REQ-030 instr_count SHALL increment by 1, wrapping 255->0, on the edge ending EXEC for MOV/MVI/OUT and on the edge ending WB for ALU.
REQ-031 imm_out SHALL hold its value until the next MVI immediate transfer.
REQ-032 A back-to-back instr_valid SHALL be accepted in the first IDLE cycle after completion; there are no bubbles beyond the FSM states.

Reset
REQ-033 While reset=0, the FSM SHALL be forced to IDLE and imm_out, the latched instruction and instr_count SHALL be 0; outputs SHALL take the REQ-027 idle values, with instr_ready=1 and busy=0.
REQ-034 Reset asserted mid-instruction (FETCH_IMM, EXEC or WB) SHALL abort the instruction immediately, issue no further load enables and not increment instr_count.

Verification
REQ-035 MOV C,B (0x24) -> exactly one cycle with source_sel=001 and destination_sel=0100; instr_count 0->1.
REQ-036 MVI D, then 0x5A after a 3-cycle valid gap -> FETCH_IMM holds; EXEC shows source_sel=100, imm_out=0x5A, destination_sel=1000.
REQ-037 ALU op=01 with C (0xA1) -> EXEC alu_b_sel=10, destination_sel=0000; WB acc_sel=0, destination_sel=0001; instr_ready low for 2 cycles.
REQ-038 OUT B (0xD0) -> single out_strobe pulse with bank_out_sel=01; 256 OUT instructions wrap instr_count to 0.
REQ-039 reset low during WB of ALU -> destination_sel=0000 immediately, instr_count unchanged, instr_ready=1.
REQ-040 Random stream of 1000 instructions -> destination_sel is at most one-hot every cycle and instr_count equals completed instructions mod 256.

Source files
------------

// File: rtl/register_bank_sequencer.sv
// register_bank_sequencer: byte-stream instruction sequencer driving the mux selects and load enables of a 4-register bank with ALU.
module register_bank_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [7:0] instr_data,
  output logic       instr_ready,
  output logic       acc_sel,
  output logic [1:0] alu_b_sel,
  output logic [1:0] bank_out_sel,
  output logic [3:0] destination_sel,
  output logic [2:0] source_sel,
  output logic [7:0] imm_out,
  output logic [1:0] alu_op,
  output logic       out_strobe,
  output logic       busy,
  output logic [7:0] instr_count
);
  typedef enum logic [1:0] {IDLE, FETCH_IMM, EXEC, WB} state_t;
  localparam logic [1:0] MOV = 2'b00, MVI = 2'b01, ALU = 2'b10, OUT = 2'b11;
  state_t state, state_nx;
  logic [7:0] instr;
  logic [1:0] cls, x, y, z;
  logic xfer;
  assign cls = instr[7:6];
  assign x = instr[5:4];
  assign y = instr[3:2];
  assign z = instr[1:0];
  assign instr_ready = state == IDLE || state == FETCH_IMM;
  assign busy = state != IDLE;
  assign xfer = instr_valid && instr_ready;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      instr <= '0;
      imm_out <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && xfer) instr <= instr_data;
      if (state == FETCH_IMM && xfer) imm_out <= instr_data;
      if ((state == EXEC && cls != ALU) || state == WB) instr_count <= instr_count + 8'd1;
    end
  end
  // Outputs decode only state and the latched instruction, so reset drops them at once.
  always_comb begin
    state_nx = state;
    destination_sel = 4'b0000;
    source_sel = 3'b000;
    acc_sel = 1'b1;
    alu_b_sel = 2'b00;
    alu_op = 2'b00;
    bank_out_sel = 2'b00;
    out_strobe = 1'b0;
    case (state)
      IDLE: if (xfer) state_nx = instr_data[7:6] == MVI ? FETCH_IMM : EXEC;
      FETCH_IMM: if (xfer) state_nx = EXEC;
      EXEC: begin
        state_nx = cls == ALU ? WB : IDLE;
        case (cls)
          MOV: begin
            source_sel = {1'b0, y};
            destination_sel = 4'b0001 << x;
          end
          MVI: begin
            source_sel = 3'b100;
            destination_sel = 4'b0001 << x;
          end
          ALU: begin
            alu_b_sel = x;
            alu_op = z;
          end
          default: begin
            bank_out_sel = x;
            out_strobe = 1'b1;
          end
        endcase
      end
      default: begin
        state_nx = IDLE;
        alu_b_sel = x;
        alu_op = z;
        acc_sel = 1'b0;
        destination_sel = 4'b0001;
      end
    endcase
  end
endmodule

// File: tb/tb_register_bank_sequencer.sv
// tb_register_bank_sequencer: table vectors, hand corner sequences and a random stream checked through a scoreboard.
module tb_register_bank_sequencer;
  logic clk = 0, reset = 0, instr_valid = 0;
  logic [7:0] instr_data = 0;
  logic instr_ready, acc_sel, out_strobe, busy;
  logic [1:0] alu_b_sel, bank_out_sel, alu_op;
  logic [3:0] destination_sel;
  logic [2:0] source_sel;
  logic [7:0] imm_out, instr_count;

  register_bank_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_ready(instr_ready), .acc_sel(acc_sel), .alu_b_sel(alu_b_sel),
    .bank_out_sel(bank_out_sel), .destination_sel(destination_sel), .source_sel(source_sel),
    .imm_out(imm_out), .alu_op(alu_op), .out_strobe(out_strobe), .busy(busy),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dest;
    logic [2:0] src;
    logic acc;
    logic [1:0] bsel, op, outsel;
    logic strobe;
    logic [7:0] imm;
  } rec_t;
  typedef struct {
    logic [7:0] b;
    logic [7:0] imm;
    int gap;
    rec_t e;
  } vec_t;

  int checks = 0, errors = 0;
  logic mon_en = 0;
  logic [7:0] cur_imm = 0, exp_count = 0, cnt_before;
  rec_t q[$];
  vec_t tbl[10];

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic rec_t mk(input logic [3:0] d, input logic [2:0] s, input logic a,
                              input logic [1:0] bs, input logic [1:0] o, input logic [1:0] os, input logic st);
    rec_t r;
    r = '{dest: d, src: s, acc: a, bsel: bs, op: o, outsel: os, strobe: st, imm: 8'h00};
    return r;
  endfunction

  function automatic rec_t exp_rec(input logic [7:0] b);
    logic [3:0] oh;
    oh = 4'b0001 << b[5:4];
    case (b[7:6])
      2'b00: return mk(oh, {1'b0, b[3:2]}, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
      2'b01: return mk(oh, 3'b100, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
      2'b10: return mk(4'b0000, 3'b000, 1'b1, b[5:4], b[1:0], 2'b00, 1'b0);
      default: return mk(4'b0000, 3'b000, 1'b1, 2'b00, 2'b00, b[5:4], 1'b1);
    endcase
  endfunction

  function automatic rec_t act_rec();
    rec_t a;
    a = '{dest: destination_sel, src: source_sel, acc: acc_sel, bsel: alu_b_sel, op: alu_op,
          outsel: bank_out_sel, strobe: out_strobe, imm: imm_out};
    return a;
  endfunction

  // Every ready-low cycle is an EXEC or WB cycle and must match the next scoreboard entry.
  always @(negedge clk) begin
    rec_t a, r, d;
    if (mon_en) begin
      a = act_rec();
      check("onehot_dest", 32'($countones(destination_sel) <= 1), 32'd1);
      if (!instr_ready) begin
        check("busy_active", 32'(busy), 32'd1);
        if (q.size() == 0) check("unexpected_active_cycle", 32'(a), 32'hFFFF_FFFF);
        else begin
          r = q.pop_front();
          check("active_outputs", 32'(a), 32'(r));
        end
      end else begin
        d = mk(4'b0000, 3'b000, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        a.imm = 8'h00;
        check("idle_outputs", 32'(a), 32'(d));
      end
    end
  end

  task automatic issue(input logic [7:0] b, input logic [7:0] imm, input int gap, input rec_t e);
    int n = 0;
    rec_t w;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(instr_ready), 32'd1);
    if (b[7:6] == 2'b01) cur_imm = imm;
    e.imm = cur_imm;
    q.push_back(e);
    if (b[7:6] == 2'b10) begin
      w = mk(4'b0001, 3'b000, 1'b0, e.bsel, e.op, 2'b00, 1'b0);
      w.imm = cur_imm;
      q.push_back(w);
    end
    exp_count++;
    instr_valid = 1;
    instr_data = b;
    @(negedge clk);
    instr_valid = 0;
    instr_data = 8'($urandom);
    if (b[7:6] == 2'b01) begin
      repeat (gap) begin
        check("fetch_hold", 32'({instr_ready, busy}), 32'd3);
        @(negedge clk);
      end
      check("fetch_wait", 32'({instr_ready, busy}), 32'd3);
      instr_valid = 1;
      instr_data = imm;
      @(negedge clk);
      instr_valid = 0;
    end
    check("latency", 32'(instr_ready), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q.size() != 0 || busy); i++) @(negedge clk);
    check("drain_queue", 32'(q.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
    check("instr_count", 32'(instr_count), 32'(exp_count));
  endtask

  initial begin
    tbl[0] = '{8'h24, 8'h00, 0, mk(4'b0100, 3'b001, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0)};
    tbl[1] = '{8'h70, 8'h5A, 3, mk(4'b1000, 3'b100, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0)};
    tbl[2] = '{8'hA1, 8'h00, 0, mk(4'b0000, 3'b000, 1'b1, 2'b10, 2'b01, 2'b00, 1'b0)};
    tbl[3] = '{8'hD0, 8'h00, 0, mk(4'b0000, 3'b000, 1'b1, 2'b00, 2'b00, 2'b01, 1'b1)};
    tbl[4] = '{8'h3C, 8'h00, 0, mk(4'b1000, 3'b011, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0)};
    tbl[5] = '{8'h00, 8'h00, 0, mk(4'b0001, 3'b000, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0)};
    tbl[6] = '{8'h40, 8'hFF, 0, mk(4'b0001, 3'b100, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0)};
    tbl[7] = '{8'h8F, 8'h00, 0, mk(4'b0000, 3'b000, 1'b1, 2'b00, 2'b11, 2'b00, 1'b0)};
    tbl[8] = '{8'hF3, 8'h00, 0, mk(4'b0000, 3'b000, 1'b1, 2'b00, 2'b00, 2'b11, 1'b1)};
    tbl[9] = '{8'h18, 8'h00, 0, mk(4'b0010, 3'b010, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0)};
    @(negedge clk);
    check("reset_outputs", 32'(act_rec()), 32'(mk(4'b0000, 3'b000, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0)));
    check("reset_ready_busy", 32'({instr_ready, busy}), 32'd2);
    check("reset_count", 32'(instr_count), 32'd0);
    reset = 1;
    @(negedge clk);
    // Abort an ALU op in its WB cycle; count stays 0 both by abort and by reset.
    instr_valid = 1;
    instr_data = 8'hA1;
    @(negedge clk);
    instr_valid = 0;
    check("abort_exec", 32'(act_rec()), 32'(mk(4'b0000, 3'b000, 1'b1, 2'b10, 2'b01, 2'b00, 1'b0)));
    check("abort_exec_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    check("abort_wb", 32'(act_rec()), 32'(mk(4'b0001, 3'b000, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0)));
    #2 reset = 0;
    #1;
    check("abort_dest", 32'(destination_sel), 32'd0);
    check("abort_ready_busy", 32'({instr_ready, busy}), 32'd2);
    check("abort_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    check("post_abort_count", 32'(instr_count), 32'd0);
    check("post_abort_dest", 32'(destination_sel), 32'd0);
    mon_en = 1;
    issue(tbl[0].b, tbl[0].imm, tbl[0].gap, tbl[0].e);
    drain();
    for (int i = 1; i < 10; i++) issue(tbl[i].b, tbl[i].imm, tbl[i].gap, tbl[i].e);
    drain();
    cnt_before = instr_count;
    for (int i = 0; i < 256; i++) issue(8'hD0, 8'h00, 0, exp_rec(8'hD0));
    drain();
    check("count_wrap", 32'(instr_count), 32'(cnt_before));
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      issue(b, 8'($urandom), int'($urandom_range(0, 2)), exp_rec(b));
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
